// File: rtl/dsp_chain_fp16_sop2_pipe.sv
// Chain of fp16 sum-of-two-products stages (fp32 chain sum) feeding a credit-controlled FWFT FIFO.
// Optional sticky inf/NaN output flag is enabled by defining DSP_CHAIN_OVF_FLAG_EN.

module fp16_sop2_mult #(
    parameter int PRIM_LAT = 1
) (
    input  logic        clk,
    input  logic [15:0] i_top_a,
    input  logic [15:0] i_top_b,
    input  logic [15:0] i_bot_a,
    input  logic [15:0] i_bot_b,
    input  logic [31:0] i_chainin,
    output logic [31:0] o_chainout
);

    // fp16 x fp16 is exact in fp32: 22-bit product significand, exponent always in normal range.
    function automatic logic [31:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
        logic        a_inf, b_inf, a_nan, b_nan, a_zero, b_zero;
        logic [10:0] sig_a, sig_b;
        logic [21:0] sig_p;
        logic [23:0] norm;
        int          lead, exp_p;
        a_inf  = (a[14:10] == 5'h1F) && (a[9:0] == 10'h0);
        b_inf  = (b[14:10] == 5'h1F) && (b[9:0] == 10'h0);
        a_nan  = (a[14:10] == 5'h1F) && (a[9:0] != 10'h0);
        b_nan  = (b[14:10] == 5'h1F) && (b[9:0] != 10'h0);
        a_zero = (a[14:0] == 15'h0);
        b_zero = (b[14:0] == 15'h0);
        sig_a  = {(a[14:10] != 5'h0), a[9:0]};
        sig_b  = {(b[14:10] != 5'h0), b[9:0]};
        sig_p  = sig_a * sig_b;
        lead   = 0;
        for (int k = 0; k < 22; k++) begin
            if (sig_p[k]) lead = k;
        end
        exp_p = lead + 77 + ((a[14:10] == 5'h0) ? 1 : int'(a[14:10]))
                          + ((b[14:10] == 5'h0) ? 1 : int'(b[14:10]));
        norm  = {2'b00, sig_p} << (23 - lead);
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return 32'h7FC0_0000;
        if (a_inf || b_inf) return {a[15] ^ b[15], 8'hFF, 23'h0};
        if (!norm[23]) return {a[15] ^ b[15], 31'h0};
        return {a[15] ^ b[15], exp_p[7:0], norm[22:0]};
    endfunction

    // Round-to-nearest-even fp32 add; subnormal inputs are treated as zero.
    function automatic logic [31:0] fp32_add(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] a, b;
        logic [7:0]  diff;
        logic [26:0] mb_full, mb, norm;
        logic [27:0] sum;
        logic [24:0] man_r;
        logic        rnd;
        int          exp_r, lz;
        if (x[30:23] == 8'hFF || y[30:23] == 8'hFF) begin
            if ((x[30:23] == 8'hFF && x[22:0] != 23'h0) || (y[30:23] == 8'hFF && y[22:0] != 23'h0) ||
                (x[30:23] == 8'hFF && y[30:23] == 8'hFF && x[31] != y[31]))
                return 32'h7FC0_0000;
            return (x[30:23] == 8'hFF) ? x : y;
        end
        if (x[30:23] == 8'h0 && y[30:23] == 8'h0) return {x[31] & y[31], 31'h0};
        if (x[30:23] == 8'h0) return y;
        if (y[30:23] == 8'h0) return x;
        if (y[30:0] > x[30:0]) begin
            a = y;
            b = x;
        end else begin
            a = x;
            b = y;
        end
        diff    = a[30:23] - b[30:23];
        mb_full = {1'b1, b[22:0], 3'b000};
        if (diff > 8'd26) begin
            mb = 27'd1;
        end else begin
            mb    = mb_full >> diff;
            mb[0] = mb[0] | (|(mb_full & ((27'd1 << diff) - 27'd1)));
        end
        if (a[31] == b[31]) sum = {2'b01, a[22:0], 3'b000} + {1'b0, mb};
        else                sum = {2'b01, a[22:0], 3'b000} - {1'b0, mb};
        if (sum == 28'h0) return 32'h0;
        exp_r = int'(a[30:23]);
        if (sum[27]) begin
            norm  = {sum[27:2], sum[1] | sum[0]};
            exp_r = exp_r + 1;
        end else begin
            lz = 0;
            for (int k = 0; k < 27; k++) begin
                if (sum[k]) lz = 26 - k;
            end
            norm  = sum[26:0] << lz;
            exp_r = exp_r - lz;
        end
        rnd   = norm[2] & (norm[1] | norm[0] | norm[3]);
        man_r = {1'b0, norm[26:3]} + {24'h0, rnd};
        if (man_r[24]) begin
            exp_r = exp_r + 1;
            man_r = man_r >> 1;
        end
        if (exp_r >= 255) return {a[31], 8'hFF, 23'h0};
        if (exp_r <= 0) return {a[31], 31'h0};
        return {a[31], exp_r[7:0], man_r[22:0]};
    endfunction

    logic [31:0] w_sum;
    logic [31:0] r_pipe [PRIM_LAT];

    assign w_sum = fp32_add(fp32_add(fp16_mul(i_top_a, i_top_b), fp16_mul(i_bot_a, i_bot_b)), i_chainin);

    // NOTE: pure data pipeline with no reset; the valid shift register alone decides when it matters.
    always_ff @(posedge clk) begin
        r_pipe[0] <= w_sum;
        for (int k = 1; k < PRIM_LAT; k++) r_pipe[k] <= r_pipe[k-1];
    end

    assign o_chainout = r_pipe[PRIM_LAT-1];

endmodule

module dsp_chain_fp16_sop2_pipe #(
    parameter int N_STAGES   = 4,
    parameter int PRIM_LAT   = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [16*N_STAGES-1:0] in_top_a,
    input  logic [16*N_STAGES-1:0] in_top_b,
    input  logic [16*N_STAGES-1:0] in_bot_a,
    input  logic [16*N_STAGES-1:0] in_bot_b,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [31:0]           out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  ovf_flag
);

    localparam int PIPE_LAT = N_STAGES * PRIM_LAT;
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int CW       = AW + 1;

    logic                         w_accept, w_push, w_pop;
    logic [16*N_STAGES-1:0]       r_top_a, r_top_b, r_bot_a, r_bot_b;
    logic [PIPE_LAT:0]            r_vld;
    logic [CW-1:0]                r_in_flight, r_count;
    logic [AW-1:0]                r_wr_ptr, r_rd_ptr;
    logic [31:0]                  r_mem [FIFO_DEPTH];
    logic [N_STAGES:0][31:0]      w_chain;

    assign w_chain[0] = 32'h0;
    assign w_accept   = in_valid & in_ready;
    assign w_push     = r_vld[PIPE_LAT];
    assign w_pop      = out_valid & out_ready;

    // Credits cover both queued and in-flight beats because the stages cannot be stalled.
    assign in_ready  = reset && (({1'b0, r_in_flight} + {1'b0, r_count}) < (CW+1)'(FIFO_DEPTH));
    assign out_valid = reset && (r_count != '0);
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : 32'h0;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_top_a <= in_top_a;
            r_top_b <= in_top_b;
            r_bot_a <= in_bot_a;
            r_bot_b <= in_bot_b;
        end
    end

    for (genvar i = 0; i < N_STAGES; i++) begin : g_stage
        logic [63:0] w_ops;
        if (i == 0) begin : g_noskew
            assign w_ops = {r_top_a[15:0], r_top_b[15:0], r_bot_a[15:0], r_bot_b[15:0]};
        end else begin : g_skew
            logic [63:0] r_skew [i*PRIM_LAT];
            always_ff @(posedge clk) begin
                r_skew[0] <= {r_top_a[16*i +: 16], r_top_b[16*i +: 16],
                              r_bot_a[16*i +: 16], r_bot_b[16*i +: 16]};
                for (int k = 1; k < i*PRIM_LAT; k++) r_skew[k] <= r_skew[k-1];
            end
            assign w_ops = r_skew[i*PRIM_LAT-1];
        end

        fp16_sop2_mult #(.PRIM_LAT(PRIM_LAT)) u_sop2 (
            .clk       (clk),
            .i_top_a   (w_ops[63:48]),
            .i_top_b   (w_ops[47:32]),
            .i_bot_a   (w_ops[31:16]),
            .i_bot_b   (w_ops[15:0]),
            .i_chainin (w_chain[i]),
            .o_chainout(w_chain[i+1])
        );
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_vld       <= '0;
            r_in_flight <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
        end else begin
            r_vld <= {r_vld[PIPE_LAT-1:0], w_accept};
            if (w_accept && !w_push)      r_in_flight <= r_in_flight + 1'b1;
            else if (!w_accept && w_push) r_in_flight <= r_in_flight - 1'b1;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_chain[N_STAGES];
    end

`ifdef DSP_CHAIN_OVF_FLAG_EN
    logic r_ovf;
    always_ff @(posedge clk) begin
        if (!reset)                                         r_ovf <= 1'b0;
        else if (w_push && w_chain[N_STAGES][30:23] == 8'hFF) r_ovf <= 1'b1;
    end
    assign ovf_flag = reset & r_ovf;
`else
    assign ovf_flag = 1'b0;
`endif

endmodule

// File: tb/tb_dsp_chain_fp16_sop2_pipe.sv
// Self-checking bench for dsp_chain_fp16_sop2_pipe: vector table, scoreboard, corner sequences.
// Expects ovf_flag behaviour according to DSP_CHAIN_OVF_FLAG_EN.

module tb_dsp_chain_fp16_sop2_pipe;

`ifdef DSP_CHAIN_OVF_FLAG_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    typedef struct {
        logic [63:0] ta, tb, ba, bb;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] in_top_a = '0, in_top_b = '0, in_bot_a = '0, in_bot_b = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        ovf_flag;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] sb [$];
    int          cyc = 0;
    int          n_pop = 0, first_pop = 0, last_pop = 0;
    bit          mon_depth = 1'b0;
    bit          hold_pend = 1'b0;
    logic [31:0] hold_data = '0;
    vec_t        vecs [10];

    dsp_chain_fp16_sop2_pipe dut (
        .clk      (clk),
        .reset    (reset),
        .in_top_a (in_top_a),
        .in_top_b (in_top_b),
        .in_bot_a (in_bot_a),
        .in_bot_b (in_bot_b),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .ovf_flag (ovf_flag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] i2h(input int v);
        int m, p;
        m = (v < 0) ? -v : v;
        p = 0;
        if (m == 0) return 16'h0;
        for (int k = 0; k < 11; k++) if ((m >> k) != 0) p = k;
        return {v < 0, 5'(p + 15), 10'((m << (10 - p)) & 32'h3FF)};
    endfunction

    function automatic logic [31:0] i2f(input int v);
        int m, p;
        m = (v < 0) ? -v : v;
        p = 0;
        if (m == 0) return 32'h0;
        for (int k = 0; k < 24; k++) if ((m >> k) != 0) p = k;
        return {v < 0, 8'(p + 127), 23'((m << (23 - p)) & 32'h7F_FFFF)};
    endfunction

    // Output monitor: scoreboard compare, hold-under-stall, outstanding-beat bound.
    always @(negedge clk) begin
        if (reset) begin
            if (hold_pend)
                check(out_valid === 1'b1 && out_data === hold_data, "hold_stable", out_data, hold_data);
            hold_pend = out_valid && !out_ready;
            hold_data = out_data;
            if (out_valid && out_ready) begin
                check(sb.size() != 0, "unexpected_output", out_data, 32'h0);
                if (sb.size() != 0) begin
                    logic [31:0] e;
                    e = sb.pop_front();
                    check(out_data === e, "result", out_data, e);
                end
                if (n_pop == 0) first_pop = cyc;
                last_pop = cyc;
                n_pop++;
            end
            if (mon_depth) check(sb.size() <= 8, "outstanding_le_8", 32'(sb.size()), 32'd8);
        end else begin
            hold_pend = 1'b0;
        end
    end

    task automatic send(input logic [63:0] ta, input logic [63:0] tb, input logic [63:0] ba,
                        input logic [63:0] bb, input logic [31:0] exp);
        int n;
        n = 0;
        in_top_a = ta;
        in_top_b = tb;
        in_bot_a = ba;
        in_bot_b = bb;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(in_ready === 1'b1, "accept", {31'h0, in_ready}, 32'h1);
        if (in_ready) sb.push_back(exp);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check(sb.size() == 0, "drain", 32'(sb.size()), 32'h0);
    endtask

    task automatic rand_beat();
        logic [63:0] ta, tb, ba, bb;
        int a1, b1, a2, b2, s;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            a1 = int'($urandom_range(8)) - 4;
            b1 = int'($urandom_range(8)) - 4;
            a2 = int'($urandom_range(8)) - 4;
            b2 = int'($urandom_range(8)) - 4;
            ta[16*i +: 16] = i2h(a1);
            tb[16*i +: 16] = i2h(b1);
            ba[16*i +: 16] = i2h(a2);
            bb[16*i +: 16] = i2h(b2);
            s += a1 * b1 + a2 * b2;
        end
        send(ta, tb, ba, bb, i2f(s));
    endtask

    localparam logic [63:0] ONE = {4{16'h3C00}};

    initial begin
        logic [5:0] hist;
        int acc, nv;

        vecs[0] = '{ONE, ONE, ONE, ONE, 32'h4100_0000};
        vecs[1] = '{{4{16'h4000}}, {4{16'h4000}}, {4{16'h4000}}, {4{16'h4000}}, 32'h4200_0000};
        vecs[2] = '{{4{16'h3800}}, {4{16'h3800}}, {4{16'h3800}}, {4{16'h3800}}, 32'h4000_0000};
        vecs[3] = '{64'h0, 64'h0, 64'h0, 64'h0, 32'h0000_0000};
        vecs[4] = '{{16'h3C00, 16'h3C00, 16'h3C00, 16'hBC00}, ONE, ONE, ONE, 32'h40C0_0000};
        vecs[5] = '{{16'h3C00, 16'h3C00, 16'h3C00, 16'h3E00}, {16'h3C00, 16'h3C00, 16'h3C00, 16'h3E00},
                    ONE, ONE, 32'h4114_0000};
        vecs[6] = '{{16'h3C00, 16'h3C00, 16'h3C00, 16'h0001}, ONE, ONE, ONE, 32'h40E0_0000};
        vecs[7] = '{{4{16'h4000}}, ONE, {4{16'hBC00}}, {4{16'h4000}}, 32'h0000_0000};
        vecs[8] = '{{4{16'h7800}}, {4{16'h7800}}, {4{16'h7800}}, {4{16'h7800}}, 32'h5000_0000};
        vecs[9] = '{{16'h4400, 16'h3C00, 16'h3C00, 16'h3C00}, ONE, ONE, ONE, 32'h4130_0000};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check(in_ready === 1'b0, "reset_in_ready", {31'h0, in_ready}, 32'h0);
        check(out_valid === 1'b0, "reset_out_valid", {31'h0, out_valid}, 32'h0);
        check(out_data === 32'h0, "reset_out_data", out_data, 32'h0);
        check(ovf_flag === 1'b0, "reset_ovf", {31'h0, ovf_flag}, 32'h0);
        reset = 1'b1;
        #1;
        check(in_ready === 1'b1, "post_reset_ready", {31'h0, in_ready}, 32'h1);

        // Vector table, back to back.
        foreach (vecs[i]) send(vecs[i].ta, vecs[i].tb, vecs[i].ba, vecs[i].bb, vecs[i].exp);
        drain();

        // Single beat latency and one-cycle valid pulse.
        send(ONE, ONE, ONE, ONE, 32'h4100_0000);
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk);
            #1 hist[e-1] = out_valid;
        end
        check(hist === 6'b010000, "latency_pulse", {26'h0, hist}, 32'h10);
        drain();

        // 20 back-to-back beats, no output bubbles.
        n_pop = 0;
        for (int k = 1; k <= 20; k++)
            send({16'h3C00, 16'h3C00, 16'h3C00, i2h(k)}, ONE, ONE, ONE, i2f(k + 7));
        drain();
        check(n_pop == 20 && last_pop - first_pop == 19, "no_bubbles",
              32'(last_pop - first_pop), 32'd19);

        // Backpressure: exactly FIFO_DEPTH accepts, then in-order drain.
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 20; c++) begin
            in_top_a = {16'h3C00, 16'h3C00, 16'h3C00, i2h(acc + 1)};
            in_top_b = ONE;
            in_bot_a = ONE;
            in_bot_b = ONE;
            in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(i2f(acc + 8));
                acc++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check(acc == 8, "credit_accepts", 32'(acc), 32'd8);
        check(in_ready === 1'b0, "credit_full", {31'h0, in_ready}, 32'h0);
        out_ready = 1'b1;
        drain();

        // Random beats with out_ready toggling every cycle.
        mon_depth = 1'b1;
        fork
            begin
                for (int b = 0; b < 50; b++) rand_beat();
                drain();
                mon_depth = 1'b0;
            end
            begin
                while (mon_depth) begin
                    @(posedge clk);
                    #1 out_ready = ~out_ready;
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // Infinity through stage 2 and sticky flag.
        check(ovf_flag === 1'b0, "ovf_idle", {31'h0, ovf_flag}, 32'h0);
        send({16'h3C00, 16'h7C00, 16'h3C00, 16'h3C00}, {16'h3C00, 16'h7C00, 16'h3C00, 16'h3C00},
             ONE, ONE, 32'h7F80_0000);
        drain();
        check(ovf_flag === OVF_EN, "ovf_set", {31'h0, ovf_flag}, {31'h0, OVF_EN});
        send(ONE, ONE, ONE, ONE, 32'h4100_0000);
        drain();
        check(ovf_flag === OVF_EN, "ovf_sticky", {31'h0, ovf_flag}, {31'h0, OVF_EN});

        // Mid-operation reset discards in-flight beats.
        for (int k = 0; k < 3; k++) send(ONE, ONE, ONE, ONE, 32'h4100_0000);
        reset = 1'b0;
        sb.delete();
        #1;
        check(in_ready === 1'b0, "midreset_in_ready", {31'h0, in_ready}, 32'h0);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check(in_ready === 1'b1, "midreset_ready_after", {31'h0, in_ready}, 32'h1);
        check(ovf_flag === 1'b0, "midreset_ovf_clear", {31'h0, ovf_flag}, 32'h0);
        nv = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1 if (out_valid) nv++;
        end
        check(nv == 0, "midreset_no_output", 32'(nv), 32'h0);

        // Pipe still works after reset.
        send(vecs[9].ta, vecs[9].tb, vecs[9].ba, vecs[9].bb, vecs[9].exp);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
